// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - per-LED brightness fader driving PWM outputs
// Each channel's brightness steps toward its on/off target once per fade tick; fade_en=0 bypasses the ramp.
module led_fade_pwm #(
  parameter int N_LEDS   = 8,
  parameter int PWM_W    = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] led_in,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] pwm_out,
  output logic              settled
);

  localparam logic [PWM_W-1:0] MAX       = '1;
  localparam int               TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PWM_W:0]   STEP_W    = (PWM_W + 1)'(STEP);

  logic [N_LEDS-1:0] led_q;
  logic [PWM_W-1:0]  bright_q [N_LEDS];
  logic [PWM_W-1:0]  bright_d [N_LEDS];
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;
  logic [N_LEDS-1:0] pwm_q, pwm_d;
  logic [PWM_W-1:0]  target;
  logic [PWM_W:0]    sum;

  always_comb begin
    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
    settled    = 1'b1;
    target     = '0;
    sum        = '0;
    pwm_d      = '0;
    bright_d   = bright_q;
    for (int i = 0; i < N_LEDS; i++) begin
      target = led_q[i] ? MAX : '0;
      // Extra carry bit lets the up-step saturate at MAX instead of wrapping.
      sum    = {1'b0, bright_q[i]} + STEP_W;
      if (!fade_en) begin
        bright_d[i] = target;
      end else if (tick_q) begin
        if (bright_q[i] < target)
          bright_d[i] = (sum > {1'b0, MAX}) ? MAX : sum[PWM_W-1:0];
        else if (bright_q[i] > target)
          bright_d[i] = ({1'b0, bright_q[i]} < STEP_W) ? '0 : bright_q[i] - STEP_W[PWM_W-1:0];
      end
      // Full brightness is forced high so the counter wrap never drops a cycle.
      pwm_d[i] = (bright_q[i] == MAX) || (pwm_cnt_q < bright_q[i]);
      if (bright_q[i] != target) settled = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q      <= '0;
      bright_q   <= '{default: '0};
      pwm_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      pwm_q      <= '0;
    end else begin
      led_q      <= led_in;
      bright_q   <= bright_d;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - self-checking bench for led_fade_pwm
// Compares outputs every cycle against a cycle-indexed arithmetic reference model.
module tb_led_fade_pwm;

  localparam int N   = 8;
  localparam int D   = 4;
  localparam int S   = 64;
  localparam int MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_in;
  logic       fade_en;
  logic [7:0] pwm_out;
  logic       settled;
  logic [7:0] led2;
  logic       fe2;
  logic [7:0] pwm2;
  logic       set2;

  always #10 clk = ~clk;

  led_fade_pwm #(.N_LEDS(N), .PWM_W(8), .TICK_DIV(D), .STEP(S)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .fade_en(fade_en),
    .pwm_out(pwm_out), .settled(settled)
  );

  // Slow-tick instance holds a single brightness level long enough to measure duty.
  led_fade_pwm #(.N_LEDS(N), .PWM_W(8), .TICK_DIV(600), .STEP(S)) dut_duty (
    .clk(clk), .rst(rst), .led_in(led2), .fade_en(fe2),
    .pwm_out(pwm2), .settled(set2)
  );

  typedef struct {
    logic [7:0] led;
    logic [7:0] exp_pwm;
    int         exp_low;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k;
  int         mb [N];
  logic [7:0] mled;
  logic [7:0] mpwm;
  logic       mset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic model_reset();
    k    = 0;
    mled = '0;
    mpwm = '0;
    mset = 1'b1;
    for (int i = 0; i < N; i++) mb[i] = 0;
  endtask

  task automatic step();
    logic [7:0] li;
    logic       fe;
    logic [7:0] np;
    int         nb [N];
    bit         tp;
    int         t;
    li = led_in;
    fe = fade_en;
    @(posedge clk);
    k++;
    tp = (k > 1) && (((k - 1) % D) == 0);
    for (int i = 0; i < N; i++) begin
      t     = mled[i] ? MAX : 0;
      np[i] = (mb[i] == MAX) || (((k - 1) % 256) < mb[i]);
      if (!fe)                  nb[i] = t;
      else if (tp && mb[i] < t) nb[i] = (mb[i] + S > MAX) ? MAX : mb[i] + S;
      else if (tp && mb[i] > t) nb[i] = (mb[i] < S) ? 0 : mb[i] - S;
      else                      nb[i] = mb[i];
    end
    mpwm = np;
    mled = li;
    mset = 1'b1;
    for (int i = 0; i < N; i++) begin
      mb[i] = nb[i];
      if (mb[i] != (mled[i] ? MAX : 0)) mset = 1'b0;
    end
    #1;
    check("pwm_out", pwm_out, mpwm);
    check("settled", settled, mset);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #25;
    model_reset();
    check("rst_pwm", pwm_out, 8'h00);
    check("rst_settled", settled, 1'b1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs [5];
  int   first_set;
  int   cnt;
  int   lows;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1};
    vecs[1] = '{8'hA5, 8'hA5, 0};
    vecs[2] = '{8'hFF, 8'hFF, 1};
    vecs[3] = '{8'h3C, 8'h3C, 1};
    vecs[4] = '{8'h00, 8'h00, 1};
    led2    = 8'h08;
    fe2     = 1'b1;

    rst     = 1'b0;
    led_in  = 8'hFF;
    fade_en = 1'b1;
    do_reset();

    // Ramp up with saturation, then constant high across a counter wrap.
    led_in    = 8'h00;
    fade_en   = 1'b1;
    do_reset();
    led_in    = 8'h01;
    first_set = -1;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (settled && first_set < 0) first_set = e;
    end
    check("ramp_up_settle_edge", first_set, 17);
    cnt = 0;
    for (int e = 0; e < 300; e++) begin
      step();
      if (!pwm_out[0]) cnt++;
    end
    check("full_on_low_cycles", cnt, 0);

    // Ramp down to the floor.
    led_in    = 8'h00;
    first_set = -1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (settled && first_set < 0) first_set = e;
    end
    check("ramp_down_settle_steps", first_set, 16);
    cnt = 0;
    for (int e = 0; e < 300; e++) begin
      step();
      if (pwm_out[0]) cnt++;
    end
    check("off_high_cycles", cnt, 0);

    // Bypass vectors.
    led_in  = 8'h00;
    fade_en = 1'b0;
    do_reset();
    for (int v = 0; v < 5; v++) begin
      led_in = vecs[v].led;
      lows   = 0;
      for (int e = 0; e < 3; e++) begin
        step();
        if (!settled) lows++;
      end
      check("bypass_pwm", pwm_out, vecs[v].exp_pwm);
      check("bypass_settled_lows", lows, vecs[v].exp_low);
    end

    // Reversal mid-ramp: 128 -> 64 -> 0, no restart from full.
    led_in  = 8'h00;
    fade_en = 1'b1;
    do_reset();
    led_in = 8'h02;
    for (int e = 1; e <= 9; e++) step();
    led_in    = 8'h00;
    first_set = -1;
    for (int e = 10; e <= 20; e++) begin
      step();
      if (settled && first_set < 0) first_set = e;
    end
    check("reversal_settle_edge", first_set, 17);

    // Asynchronous reset mid-ramp clears outputs without a clock edge.
    led_in = 8'h00;
    do_reset();
    led_in = 8'h01;
    for (int e = 1; e <= 10; e++) step();
    check("pre_async_pwm0", pwm_out[0], 1'b1);
    #4;
    rst = 1'b0;
    #1;
    check("async_pwm", pwm_out, 8'h00);
    check("async_settled", settled, 1'b1);
    do_reset();

    // Duty at brightness 64 on the slow-tick instance.
    led_in = 8'h00;
    do_reset();
    cnt = 0;
    for (int e = 1; e <= 865; e++) begin
      step();
      if (e >= 610 && pwm2[3]) cnt++;
    end
    check("duty_64", cnt, 64);

    // Randomized traffic against the model.
    do_reset();
    for (int e = 0; e < 3000; e++) begin
      step();
      if ($urandom_range(0, 5) == 0)  led_in  = 8'($urandom);
      if ($urandom_range(0, 40) == 0) fade_en = ~fade_en;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
